muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 22 ++
 rtl/muldiv_signfix.sv | 11 +
 rtl/muldiv_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Holds the M-extension ALU opcodes, the FSM state type and the iteration count.
package muldiv_sequencer_pkg;

    localparam logic [4:0] OpMul    = 5'b01000;
    localparam logic [4:0] OpMulh   = 5'b01001;
    localparam logic [4:0] OpMulhu  = 5'b01010;
    localparam logic [4:0] OpMulhsu = 5'b01011;
    localparam logic [4:0] OpDiv    = 5'b01100;
    localparam logic [4:0] OpDivu   = 5'b01101;
    localparam logic [4:0] OpRem    = 5'b01110;
    localparam logic [4:0] OpRemu   = 5'b01111;

    localparam int unsigned Iter = 32;

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    function automatic logic is_mop(input logic [4:0] op);
        return (op >= OpMul) && (op <= OpRemu);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational 32-bit conditional two's-complement negate.
// Used as abs() on operands and as sign fixup on results.
module muldiv_signfix (
    input  logic [31:0] a_i,
    input  logic        neg_i,
    output logic [31:0] y_o
);

    assign y_o = neg_i ? (~a_i + 32'd1) : a_i;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: PREP (abs), 32 radix-2 CALC steps, FIX (sign/select).
// One shared accumulator/shift-register pair serves both the multiply and divide paths.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        flush,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [31:0] op1_q, op2_q, operand_q, acc_q, shreg_q;
    logic [5:0]  cnt_q;
    logic        sign_q;

    logic        is_div, is_rem, is_mulh, signed1, signed2, neg1, neg2;
    logic        div_zero, div_ovf, fix_neg;
    logic [31:0] abs1, abs2, fix_in, fix_val, fix_result;
    logic [32:0] mul_sum, div_shift, div_diff;

    // op_q holds opcode[2:0]; bit 2 selects divide, bit 1 remainder/high variants
    assign is_div  = op_q[2];
    assign is_rem  = is_div & op_q[1];
    assign is_mulh = ~is_div & (op_q[1:0] != 2'b00);
    assign signed1 = is_div ? ~op_q[0] : op_q[0];
    assign signed2 = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
    assign neg1    = signed1 & op1_q[31];
    assign neg2    = signed2 & op2_q[31];

    assign div_zero = is_div & (op2_q == 32'd0);
    assign div_ovf  = is_div & ~op_q[0] & (op1_q == 32'h8000_0000) & (op2_q == 32'hFFFF_FFFF);

    muldiv_signfix u_abs1 (.a_i(op1_q), .neg_i(neg1), .y_o(abs1));
    muldiv_signfix u_abs2 (.a_i(op2_q), .neg_i(neg2), .y_o(abs2));

    assign mul_sum   = {1'b0, acc_q} + {1'b0, (shreg_q[0] ? operand_q : 32'd0)};
    assign div_shift = {acc_q, shreg_q[31]};
    assign div_diff  = div_shift - {1'b0, operand_q};

    // Product is {acc_q, shreg_q}; quotient is shreg_q, remainder acc_q.
    // Negating the 64-bit product only carries into the high word when the low word is zero.
    assign fix_in  = is_div ? (is_rem ? acc_q : shreg_q) : (is_mulh ? acc_q : shreg_q);
    assign fix_neg = sign_q & (~is_mulh | (shreg_q == 32'd0));

    muldiv_signfix u_fix (.a_i(fix_in), .neg_i(fix_neg), .y_o(fix_val));

    always_comb begin
        fix_result = fix_val;
        if (div_zero) begin
            fix_result = is_rem ? op1_q : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            fix_result = is_rem ? 32'd0 : 32'h8000_0000;
        end else if (is_mulh && sign_q && (shreg_q != 32'd0)) begin
            fix_result = ~acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start && is_mop(opcode)) begin
                        op_q    <= opcode[2:0];
                        op1_q   <= data1;
                        op2_q   <= data2;
                        state_q <= StPrep;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                StPrep, StCalc, StFix: begin
                    if (flush) begin
                        state_q <= StIdle;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end else if (state_q == StPrep) begin
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        sign_q    <= is_rem ? neg1 : (neg1 ^ neg2);
                        operand_q <= is_div ? abs2 : abs1;
                        shreg_q   <= is_div ? abs1 : abs2;
                        state_q   <= (div_zero || div_ovf) ? StFix : StCalc;
                    end else if (state_q == StCalc) begin
                        if (is_div) begin
                            acc_q   <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
                            shreg_q <= {shreg_q[30:0], ~div_diff[32]};
                        end else begin
                            acc_q   <= mul_sum[32:1];
                            shreg_q <= {mul_sum[0], shreg_q[31:1]};
                        end
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(Iter - 1)) begin
                            state_q <= StFix;
                        end
                    end else begin
                        result  <= fix_result;
                        done    <= 1'b1;
                        state_q <= StDone;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
